// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
// Contents: access-type encoding (funct3), FSM state encoding, default bus
// timeout and the counter-width helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam int TIMEOUT_DEF = 255;

  // A timeout of 1 would give a zero-width counter; keep at least one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - request legality check, store lane/strobe generation, load extraction
// Ports:
//   chk_*  : live decoder request (type, low address bits, rd/wr) -> legal / fault
//   fmt_*  : registered request type and low address bits used for formatting
//   st_data_i / st_data_o, st_be_o : store data replicated across lanes + byte enables
//   ld_raw_i / ld_data_o           : raw bus word -> extracted, extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  chk_type_i,
  input  logic [1:0]  chk_off_i,
  input  logic        chk_rd_i,
  input  logic        chk_wr_i,
  output logic        chk_legal_o,
  output logic        chk_fault_o,
  input  logic [2:0]  fmt_type_i,
  input  logic [1:0]  fmt_off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);

  logic       size_ok;
  logic       store_ok;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    size_ok = 1'b0;
    case (chk_type_i)
      LS_B, LS_BU: size_ok = 1'b1;
      LS_H, LS_HU: size_ok = ~chk_off_i[0];
      LS_W:        size_ok = (chk_off_i == 2'b00);
      default:     size_ok = 1'b0;
    endcase
    // Unsigned variants only make sense for loads.
    store_ok    = ~(chk_wr_i & chk_type_i[2]);
    chk_legal_o = (chk_rd_i ^ chk_wr_i) & size_ok & store_ok;
    chk_fault_o = (chk_rd_i | chk_wr_i) & ~chk_legal_o;
  end

  always_comb begin
    st_data_o = st_data_i;
    st_be_o   = 4'b1111;
    case (fmt_type_i)
      LS_B, LS_BU: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_be_o   = 4'b0001 << fmt_off_i;
      end
      LS_H, LS_HU: begin
        st_data_o = {2{st_data_i[15:0]}};
        st_be_o   = 4'b0011 << fmt_off_i;
      end
      default: begin
        st_data_o = st_data_i;
        st_be_o   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte   = ld_raw_i[{fmt_off_i, 3'b000} +: 8];
    ld_half   = ld_raw_i[{fmt_off_i[1], 4'b0000} +: 16];
    ld_data_o = ld_raw_i;
    case (fmt_type_i)
      LS_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LS_BU:   ld_data_o = {24'h0, ld_byte};
      LS_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      LS_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - handshaked load/store bus master with core stall
// Ports:
//   clock_i, reset_ni                      : clock, async active-low reset
//   mem_rd_i, mem_wr_i, rd_wr_mem_i        : decoder load/store request and funct3 type
//   addr_i, wdata_i                        : byte address (ALU result), store data
//   stall_o, rdata_o, access_fault_o, bus_err_o : core-side status and load result
//   bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o : bus request side
//   bus_rdata_i, bus_ack_i                 : bus response side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  rd_wr_mem_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        access_fault_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       addr_q, wdata_q;
  logic [2:0]        type_q;
  logic              we_q;
  logic              capture;
  logic              stall;
  logic              fault;

  logic        chk_legal, chk_fault;
  logic [31:0] st_data, ld_data;
  logic [3:0]  st_be;

  lsu_align u_align (
    .chk_type_i  (rd_wr_mem_i),
    .chk_off_i   (addr_i[1:0]),
    .chk_rd_i    (mem_rd_i),
    .chk_wr_i    (mem_wr_i),
    .chk_legal_o (chk_legal),
    .chk_fault_o (chk_fault),
    .fmt_type_i  (type_q),
    .fmt_off_i   (addr_q[1:0]),
    .st_data_i   (wdata_q),
    .ld_raw_i    (bus_rdata_i),
    .st_data_o   (st_data),
    .st_be_o     (st_be),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        type_q  <= rd_wr_mem_i;
        we_q    <= mem_wr_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    stall   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      IDLE: begin
        if (chk_legal) begin
          stall   = 1'b1;
          capture = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end else begin
          fault = chk_fault;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack_i) begin
          // Stores have nothing to return; keep rdata quiet for them.
          rdata_d = we_q ? 32'h0 : ld_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational status is gated by reset so every output is 0 while held.
  assign stall_o        = reset_ni & stall;
  assign access_fault_o = reset_ni & fault;
  assign rdata_o        = (state_q == DONE) ? rdata_q : 32'h0;
  assign bus_err_o      = (state_q == DONE) & err_q;

  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = bus_req_o & we_q;
  assign bus_addr_o  = bus_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_wdata_o = bus_req_o ? st_data : 32'h0;
  assign bus_be_o    = bus_req_o ? st_be : 4'h0;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the core's ALU/decoder and replaces the zero-latency data memory port with a handshaked bus master.
- Takes the ALU result as a byte address and the decoder's load/store controls.
- Drives a word-addressed, byte-strobed memory bus and stalls the core until the access completes.
- Performs store-lane replication, load extraction with sign/zero extension, misalignment detection and bus timeout.

Parameters:
- TIMEOUT, 255: maximum cycles in REQ waiting for bus_ack before the access is aborted with bus_err.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_rd  input  1  load request from decoder.
- mem_wr  input  1  store request from decoder.
- rd_wr_mem  input  3  access type (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rs2).
- stall  output  1  hold PC/register writeback while high.
- rdata  output  32  formatted load data, valid in DONE.
- access_fault  output  1  misaligned/illegal request; no bus access performed.
- bus_err  output  1  timeout abort, valid in DONE.
- bus_req  output  1  bus request, held until ack.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- bus_wdata  output  32  lane-replicated store data.
- bus_be  output  4  byte enables.
- bus_rdata  input  32  read data, valid with bus_ack.
- bus_ack  input  1  single-cycle completion strobe.

Behaviour:
- Reset (async, low): state = IDLE, counter = 0, captured rdata = 0, err flag = 0. All outputs 0 while reset is low; bus_req drops immediately, even mid-access.
- Legal request = exactly one of mem_rd/mem_wr, with alignment satisfied:
  - H/HU: addr[0] = 0.
  - W: addr[1:0] = 00.
  - Encodings 011/110/111 are illegal; stores with 100/101 are illegal.
- IDLE:
  - Legal request: stall = 1 combinationally. Register addr/wdata/type/we, go to REQ.
  - Illegal request, or mem_rd and mem_wr both high: access_fault = 1 combinationally, stall = 0, no state change, rdata = 0.
  - No request: stall = 0.
- REQ:
  - bus_req = 1, stall = 1. Bus signals are driven from registered copies and stay stable until ack.
  - bus_ack: capture formatted bus_rdata, go to DONE.
  - Counter increments each REQ cycle without ack. When counter = TIMEOUT-1 and no ack: go to DONE with err flag = 1, rdata = 0.
- DONE:
  - stall = 0; rdata and bus_err are driven from registers.
  - Unconditionally go to IDLE, clearing counter and err. The core's instruction during DONE is the completed one and is never relaunched.
- Minimum occupancy is 3 cycles (IDLE, REQ with same-cycle ack, DONE). Ack arriving outside REQ is ignored.
- Store formatting:
  - B: bus_wdata = {4{wdata[7:0]}}, bus_be = 0001 << addr[1:0].
  - H: bus_wdata = {2{wdata[15:0]}}, bus_be = 0011 << addr[1:0].
  - W: bus_wdata = wdata, bus_be = 1111.
- Loads: bus_be uses the same size rule. Extract the byte/half selected by addr[1:0]. B/H sign-extend from the top bit; BU/HU zero-extend.
- All address arithmetic is 32-bit with no wrap handling needed, because the word address is a truncation.

Decomposition:
- lsu_pkg:
  - access-type enum (LS_B = 3'b000, LS_H, LS_W, LS_BU = 3'b100, LS_HU).
  - state enum (IDLE, REQ, DONE).
  - TIMEOUT default constant.
  - counter width computed as $clog2(TIMEOUT).
- One combinational sub-module, lsu_align: store lane/strobe generation, load extraction/extension and alignment check.
- The FSM, counter and capture registers live in load_store_unit.

Test Plan:
- Reset low during REQ (bus_ack never given) → bus_req = 0 same cycle; after release, state IDLE and stall = 0.
- SW addr = 0x0000_1004, wdata = 0xDEAD_BEEF, ack on 2nd REQ cycle → bus_addr = 0x1004, be = 1111, bus_wdata = 0xDEADBEEF, we = 1; stall high 3 cycles, low in DONE.
- SB addr = 0x1003, wdata = 0x0000_00A5 → bus_addr = 0x1000, be = 1000, bus_wdata = 0xA5A5A5A5.
- LB / LBU / LH / LHU at addr 0x2002, bus_rdata = 0x80F0_1234 → rdata = 0xFFFF_FFF0, 0x0000_00F0, 0xFFFF_80F0, 0x0000_80F0.
- LW addr = 0x2001 → access_fault = 1, stall = 0, bus_req never asserted. Same for mem_rd = mem_wr = 1 at addr 0x0.
- LW with TIMEOUT = 4 and no ack → bus_req high exactly 4 cycles, then DONE with bus_err = 1 and rdata = 0, then IDLE.
